// File: rtl/vga_timing_gen.sv
// VGA raster timing for vga_disp: syncs, active enable, pixel coordinates, image ROM fetch window
// and delayed sync/enable copies for the pad stage. Define VGA_FRAME_CNT_EN for frame_start/frame_cnt.
module vga_timing_gen #(
    parameter int H_SYNC   = 136,
    parameter int H_BACK   = 160,
    parameter int H_DISP   = 1024,
    parameter int H_FRONT  = 24,
    parameter int V_SYNC   = 6,
    parameter int V_BACK   = 29,
    parameter int V_DISP   = 768,
    parameter int V_FRONT  = 3,
    parameter int IMG_X    = 384,
    parameter int IMG_Y    = 256,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int ROM_LEAD = 3,
    parameter int OUT_DLY  = 1
) (
    input  logic        clk_in,
    input  logic        rst,
    output logic        hsync,
    output logic        vsync,
    output logic        data_en,
    output logic        rom_en,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        hsync_dly,
    output logic        vsync_dly,
    output logic        de_dly
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic        frame_start,
    output logic [15:0] frame_cnt
`endif
);

    localparam int HA_I = H_SYNC + H_BACK;
    localparam int VA_I = V_SYNC + V_BACK;

    localparam logic [11:0] H_LAST   = 12'(HA_I + H_DISP + H_FRONT - 1);
    localparam logic [11:0] V_LAST   = 12'(VA_I + V_DISP + V_FRONT - 1);
    localparam logic [11:0] H_SYNC_E = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_E = 12'(V_SYNC);
    localparam logic [11:0] HA       = 12'(HA_I);
    localparam logic [11:0] VA       = 12'(VA_I);
    localparam logic [11:0] HA_END   = 12'(HA_I + H_DISP);
    localparam logic [11:0] VA_END   = 12'(VA_I + V_DISP);
    // Fetch window starts ROM_LEAD clocks ahead of the image's first column.
    localparam logic [11:0] ROM_H0   = 12'(HA_I + IMG_X - ROM_LEAD);
    localparam logic [11:0] ROM_H1   = 12'(HA_I + IMG_X - ROM_LEAD + IMG_W);
    localparam logic [11:0] ROM_V0   = 12'(VA_I + IMG_Y);
    localparam logic [11:0] ROM_V1   = 12'(VA_I + IMG_Y + IMG_H);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        h_last;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        rom_q, rom_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        h_act, v_act;

    sync_t       dly_q [OUT_DLY];

    // Raster counters
    always_comb begin
        h_last  = (h_cnt_q == H_LAST);
        h_cnt_d = h_last ? 12'd0 : h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Decode of the current counters; registered below, so outputs trail the counters by one clock.
    always_comb begin
        hsync_d = (h_cnt_q >= H_SYNC_E);
        vsync_d = (v_cnt_q >= V_SYNC_E);
        h_act   = (h_cnt_q >= HA) && (h_cnt_q < HA_END);
        v_act   = (v_cnt_q >= VA) && (v_cnt_q < VA_END);
        de_d    = h_act && v_act;
        x_d     = '0;
        y_d     = '0;
        if (de_d) begin
            x_d = h_cnt_q - HA;
            y_d = v_cnt_q - VA;
        end
        rom_d   = (v_cnt_q >= ROM_V0) && (v_cnt_q < ROM_V1) &&
                  (h_cnt_q >= ROM_H0) && (h_cnt_q < ROM_H1);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            rom_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            rom_q   <= rom_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Delay line aligning sync/enable with vga_disp's registered pixel data.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 0; i < OUT_DLY; i++) begin
                dly_q[i] <= SYNC_IDLE;
            end
        end else begin
            dly_q[0] <= sync_t'{hs: hsync_q, vs: vsync_q, de: de_q};
            for (int i = 1; i < OUT_DLY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign data_en   = de_q;
    assign rom_en    = rom_q;
    assign x_pos     = x_q;
    assign y_pos     = y_q;
    assign hsync_dly = dly_q[OUT_DLY-1].hs;
    assign vsync_dly = dly_q[OUT_DLY-1].vs;
    assign de_dly    = dly_q[OUT_DLY-1].de;

`ifdef VGA_FRAME_CNT_EN
    logic        fs_q, fs_d;
    logic [15:0] fc_q, fc_d;

    always_comb begin
        fs_d = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        fc_d = fs_d ? fc_q + 16'd1 : fc_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            fs_q <= 1'b0;
            fc_q <= '0;
        end else begin
            fs_q <= fs_d;
            fc_q <= fc_d;
        end
    end

    assign frame_start = fs_q;
    assign frame_cnt   = fc_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (20x12 clocks per frame),
// with OUT_DLY=3 and OUT_DLY=1 instances side by side.
module tb_vga_timing_gen;

    localparam int HS = 4,  HB = 3, HD = 10, HF = 3;
    localparam int VS = 2,  VB = 2, VD = 6,  VF = 2;
    localparam int IX = 3,  IY = 2, IW = 4,  IH = 3, RL = 3;
    localparam int HT = HS + HB + HD + HF;   // 20
    localparam int VT = VS + VB + VD + VF;   // 12
    localparam int FT = HT * VT;             // 240 clocks per frame
    localparam int HA = HS + HB;             // 7
    localparam int VA = VS + VB;             // 4

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic hs3, vs3, de3, rom3, hsd3, vsd3, ded3;
    logic hs1, vs1, de1, rom1, hsd1, vsd1, ded1;
    logic [11:0] x3, y3, x1, y1;
`ifdef VGA_FRAME_CNT_EN
    logic fs3, fs1;
    logic [15:0] fc3, fc1;
`endif

    vga_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .IMG_X(IX), .IMG_Y(IY), .IMG_W(IW), .IMG_H(IH), .ROM_LEAD(RL), .OUT_DLY(3)
    ) u_d3 (
        .clk_in(clk), .rst(rst), .hsync(hs3), .vsync(vs3), .data_en(de3), .rom_en(rom3),
        .x_pos(x3), .y_pos(y3), .hsync_dly(hsd3), .vsync_dly(vsd3), .de_dly(ded3)
`ifdef VGA_FRAME_CNT_EN
        , .frame_start(fs3), .frame_cnt(fc3)
`endif
    );

    vga_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .IMG_X(IX), .IMG_Y(IY), .IMG_W(IW), .IMG_H(IH), .ROM_LEAD(RL), .OUT_DLY(1)
    ) u_d1 (
        .clk_in(clk), .rst(rst), .hsync(hs1), .vsync(vs1), .data_en(de1), .rom_en(rom1),
        .x_pos(x1), .y_pos(y1), .hsync_dly(hsd1), .vsync_dly(vsd1), .de_dly(ded1)
`ifdef VGA_FRAME_CNT_EN
        , .frame_start(fs1), .frame_cnt(fc1)
`endif
    );

    typedef struct {
        logic        hs;
        logic        vs;
        logic        de;
        logic        rom;
        logic [11:0] x;
        logic [11:0] y;
    } exp_t;

    typedef struct {
        int          k;
        logic        hs;
        logic        vs;
        logic        de;
        logic        rom;
        logic [11:0] x;
        logic [11:0] y;
    } vec_t;

    int nvec = 0;
    int nfail = 0;
    int k = 0;   // edges since reset release; outputs at edge k reflect counters (k-1)
    int n_rom, n_de, n_hsl, n_vsl, n_hfall;
    logic prev_hs;
    logic [15:0] fc_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at k=%0d: got %0h, expected %0h", nm, k, act, exp);
        end
    endtask

    // Reference decode from the raster position implied by k.
    function automatic exp_t model(input int kk);
        exp_t e;
        int t, h, v;
        e = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rom: 1'b0, x: 12'd0, y: 12'd0};
        if (kk >= 1) begin
            t = kk - 1;
            h = t % HT;
            v = (t / HT) % VT;
            e.hs  = !(h < HS);
            e.vs  = !(v < VS);
            e.de  = (h >= HA) && (h < HA + HD) && (v >= VA) && (v < VA + VD);
            e.x   = e.de ? 12'(h - HA) : 12'd0;
            e.y   = e.de ? 12'(v - VA) : 12'd0;
            e.rom = (v >= VA + IY) && (v < VA + IY + IH) &&
                    (h >= HA + IX - RL) && (h < HA + IX - RL + IW);
        end
        return e;
    endfunction

    task automatic step();
        exp_t e, e3, e1;
        @(posedge clk);
        #1;
        k++;
        e  = model(k);
        e3 = model(k - 3);
        e1 = model(k - 1);
        chk("hsync", hs3, e.hs);
        chk("vsync", vs3, e.vs);
        chk("data_en", de3, e.de);
        chk("rom_en", rom3, e.rom);
        chk("x_pos", x3, e.x);
        chk("y_pos", y3, e.y);
        chk("hsync_dly3", hsd3, e3.hs);
        chk("vsync_dly3", vsd3, e3.vs);
        chk("de_dly3", ded3, e3.de);
        chk("hsync_dly1", hsd1, e1.hs);
        chk("vsync_dly1", vsd1, e1.vs);
        chk("de_dly1", ded1, e1.de);
        chk("rom_en_d1", rom1, e.rom);
        if (k > FT && k <= 2 * FT) begin
            n_rom += int'(rom3);
            n_de  += int'(de3);
            n_hsl += int'(!hs3);
            n_vsl += int'(!vs3);
            if (prev_hs && !hs3) n_hfall++;
        end
        prev_hs = hs3;
`ifdef VGA_FRAME_CNT_EN
        if ((k - 1) % FT == 0) fc_m = fc_m + 16'd1;
        chk("frame_start", fs3, ((k - 1) % FT == 0));
        chk("frame_cnt", fc3, fc_m);
`endif
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hsync"}, hs3, 1'b1);
        chk({tag, "_vsync"}, vs3, 1'b1);
        chk({tag, "_de"}, de3, 1'b0);
        chk({tag, "_rom"}, rom3, 1'b0);
        chk({tag, "_x"}, x3, 12'd0);
        chk({tag, "_y"}, y3, 12'd0);
        chk({tag, "_hsd"}, hsd3, 1'b1);
        chk({tag, "_vsd"}, vsd3, 1'b1);
        chk({tag, "_ded"}, ded3, 1'b0);
        chk({tag, "_rom_d1"}, rom1, 1'b0);
        chk({tag, "_ded_d1"}, ded1, 1'b0);
`ifdef VGA_FRAME_CNT_EN
        chk({tag, "_fs"}, fs3, 1'b0);
        chk({tag, "_fc"}, fc3, 16'd0);
`endif
    endtask

    initial begin
        vec_t tbl [18];
        tbl[0]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0};
        tbl[1]  = '{4,   1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0};
        tbl[2]  = '{5,   1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0};
        tbl[3]  = '{21,  1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0};
        tbl[4]  = '{41,  1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0};
        tbl[5]  = '{88,  1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0};
        tbl[6]  = '{97,  1'b1, 1'b1, 1'b1, 1'b0, 12'd9, 12'd0};
        tbl[7]  = '{98,  1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0};
        tbl[8]  = '{108, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd1};
        tbl[9]  = '{127, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0};
        tbl[10] = '{128, 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, 12'd2};
        tbl[11] = '{131, 1'b1, 1'b1, 1'b1, 1'b1, 12'd3, 12'd2};
        tbl[12] = '{132, 1'b1, 1'b1, 1'b1, 1'b0, 12'd4, 12'd2};
        tbl[13] = '{168, 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, 12'd4};
        tbl[14] = '{188, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd5};
        tbl[15] = '{208, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0};
        tbl[16] = '{241, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0};
        tbl[17] = '{248, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0};

        n_rom = 0; n_de = 0; n_hsl = 0; n_vsl = 0; n_hfall = 0;
        prev_hs = 1'b1;
        fc_m = 16'd0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        rst = 1'b0;

        foreach (tbl[i]) begin
            while (k < tbl[i].k) step();
            chk("tbl_hsync", hs3, tbl[i].hs);
            chk("tbl_vsync", vs3, tbl[i].vs);
            chk("tbl_de", de3, tbl[i].de);
            chk("tbl_rom", rom3, tbl[i].rom);
            chk("tbl_x", x3, tbl[i].x);
            chk("tbl_y", y3, tbl[i].y);
        end

        // Whole second frame: per-frame totals.
        while (k < 2 * FT) step();
        chk("rom_per_frame", n_rom, IW * IH);
        chk("de_per_frame", n_de, HD * VD);
        chk("hsync_low_clks", n_hsl, HS * VT);
        chk("vsync_low_clks", n_vsl, VS * HT);
        chk("hsync_falls", n_hfall, VT);

        // Mid-image reset: row y=3, x=2, inside the rom_en burst.
        while (k < 2 * FT + 150) step();
        chk("pre_rst_rom", rom3, 1'b1);
        chk("pre_rst_x", x3, 12'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("mid1");
        @(posedge clk);
        #1;
        chk_reset("mid2");
        rst = 1'b0;
        k = 0;
        fc_m = 16'd0;
        prev_hs = 1'b1;
        step();
        chk("hs_low_after_rel", hs3, 1'b0);
        while (k < FT + 20) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
